// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: SLL or SRA by 0..31 bits, at most two bits per cycle.
// Optional abort input enabled by defining SHIFT_SEQUENCER_ABORT_EN.
module shift_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
`ifdef SHIFT_SEQUENCER_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  state_dbg
);

  // Handshake: start is a request sampled only in IDLE or DONE (accepted on that
  // edge, no ready signal); done is a single-cycle completion pulse, busy marks SHIFT.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] work;
  logic [4:0]  rem;
  logic        op_q;
  logic [31:0] work_step;
  logic [4:0]  rem_step;
  logic        accept;
  logic        abort_hit;

  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef SHIFT_SEQUENCER_ABORT_EN
  assign abort_hit = abort && (state == SHIFT);
`else
  assign abort_hit = 1'b0;
`endif

  // One step of the shift: two bits while at least two remain, else one.
  always_comb begin
    work_step = work;
    rem_step  = rem;
    if (rem >= 5'd2) begin
      rem_step  = rem - 5'd2;
      work_step = op_q ? {{2{work[31]}}, work[31:2]} : {work[29:0], 2'b00};
    end else if (rem == 5'd1) begin
      rem_step  = 5'd0;
      work_step = op_q ? {work[31], work[31:1]} : {work[30:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = (shamt == 5'd0) ? DONE : SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      SHIFT: begin
        if (abort_hit) begin
          next_state = IDLE;
        end else if (rem_step == 5'd0) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SHIFT);
    done      = (state == DONE);
    state_dbg = state;
  end

  // Operand and result registers; result moves only on completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work   <= 32'd0;
      rem    <= 5'd0;
      op_q   <= 1'b0;
      result <= 32'd0;
    end else if (accept) begin
      work <= data_in;
      rem  <= shamt;
      op_q <= op;
      if (shamt == 5'd0) begin
        result <= data_in;
      end
    end else if ((state == SHIFT) && !abort_hit) begin
      work <= work_step;
      rem  <= rem_step;
      if (rem_step == 5'd0) begin
        result <= work_step;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, fill rules, back-to-back, reset and
// (with SHIFT_SEQUENCER_ABORT_EN) abort behaviour against hand-computed results.
module tb_shift_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_result;
  bit          noise;

  shift_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .data_in   (data_in),
    .shamt     (shamt),
`ifdef SHIFT_SEQUENCER_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic o, input logic [31:0] d, input logic [4:0] s,
                          input logic [31:0] exp);
    start   = 1'b1;
    op      = o;
    data_in = d;
    shamt   = s;
    exp_q.push_back(exp);
    @(negedge clock);
    start   = 1'b0;
    op      = $urandom_range(0, 1);
    data_in = $urandom;
    shamt   = 5'($urandom_range(0, 31));
  endtask

  // Counts busy cycles, checks result holds, then checks the done cycle.
  task automatic wait_done(input string tag, input int exp_busy);
    int          n;
    logic [31:0] exp;
    n   = 0;
    exp = exp_q.pop_front();
    while (busy && n < 40) begin
      check_eq({tag, " hold"}, result, prev_result);
      start = noise;
      if (noise) begin
        data_in = $urandom;
        shamt   = 5'd0;
      end
      @(negedge clock);
      start = 1'b0;
      n++;
    end
    check_eq({tag, " busy cycles"}, n, exp_busy);
    check_eq({tag, " done"}, {31'd0, done}, 32'd1);
    check_eq({tag, " result"}, result, exp);
    prev_result = exp;
  endtask

  task automatic finish_idle(input string tag);
    start = 1'b0;
    @(negedge clock);
    check_eq({tag, " done low"}, {31'd0, done}, 32'd0);
    check_eq({tag, " idle"}, {30'd0, state_dbg}, {30'd0, ST_IDLE});
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    op          = 1'b0;
    data_in     = 32'd0;
    shamt       = 5'd0;
    abort       = 1'b0;
    noise       = 1'b0;
    prev_result = 32'd0;

    repeat (2) @(negedge clock);
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    check_eq("reset done", {31'd0, done}, 32'd0);
    check_eq("reset result", result, 32'd0);
    check_eq("reset state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    reset_n = 1'b1;
    @(negedge clock);

    start_op(1'b0, 32'h0000_0001, 5'd5, 32'h0000_0020);
    wait_done("sll1x5", 3);
    finish_idle("sll1x5");

    start_op(1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    wait_done("sra8x31", 16);
    finish_idle("sra8x31");

    start_op(1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
    wait_done("sra7x31", 16);
    finish_idle("sra7x31");

    start_op(1'b0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    wait_done("zero", 0);
    finish_idle("zero");

    start_op(1'b1, 32'hF000_0000, 5'd3, 32'hFE00_0000);
    wait_done("sraodd", 2);
    finish_idle("sraodd");

    start_op(1'b0, 32'h8000_0001, 5'd1, 32'h0000_0002);
    wait_done("sll1", 1);
    finish_idle("sll1");

    // Back-to-back: new request presented during DONE.
    start_op(1'b0, 32'h0000_0001, 5'd5, 32'h0000_0020);
    wait_done("b2b first", 3);
    start_op(1'b0, 32'h0000_000F, 5'd4, 32'h0000_00F0);
    check_eq("b2b no bubble", {30'd0, state_dbg}, {30'd0, ST_SHIFT});
    wait_done("b2b second", 2);
    finish_idle("b2b");

    // start pulses with junk operands while shifting are ignored.
    noise = 1'b1;
    start_op(1'b0, 32'h0000_0003, 5'd6, 32'h0000_00C0);
    wait_done("noise", 3);
    noise = 1'b0;
    finish_idle("noise");

    // Reset in the middle of a long shift.
    start_op(1'b0, 32'h0000_0001, 5'd20, 32'h0010_0000);
    exp_q.delete();
    repeat (2) @(negedge clock);
    check_eq("rst pre busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rst state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    check_eq("rst result", result, 32'd0);
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    prev_result = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("rst no done", {31'd0, done}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    start_op(1'b1, 32'hFFFF_0000, 5'd16, 32'hFFFF_FFFF);
    wait_done("post rst", 8);
    finish_idle("post rst");

`ifdef SHIFT_SEQUENCER_ABORT_EN
    start_op(1'b0, 32'h1234_5678, 5'd0, 32'h1234_5678);
    wait_done("preload", 0);
    finish_idle("preload");

    start_op(1'b0, 32'h0000_0001, 5'd8, 32'h0000_0100);
    exp_q.delete();
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_eq("abort state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    check_eq("abort done", {31'd0, done}, 32'd0);
    check_eq("abort result", result, 32'h1234_5678);
    @(negedge clock);
    check_eq("abort later done", {31'd0, done}, 32'd0);

    // Abort on the final step wins over completion.
    start_op(1'b0, 32'h0000_0001, 5'd2, 32'h0000_0004);
    exp_q.delete();
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_eq("abort last state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    check_eq("abort last done", {31'd0, done}, 32'd0);
    check_eq("abort last result", result, 32'h1234_5678);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
